// File: rtl/cell_drawer_if.sv
// Request/LCD signal bundle for cell_drawer.
// The map scanner acts as master: it drives the request and observes
// cmd_done, busy and the LCD bus. cell_drawer uses the slave modport.
interface cell_drawer_if;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic       lcd_cs_n;
  logic       lcd_wr_n;
  logic       lcd_dc;
  logic [7:0] lcd_data;

  modport master (
    output diff, x, y, obj_code,
    input  cmd_done, busy, lcd_cs_n, lcd_wr_n, lcd_dc, lcd_data
  );

  modport slave (
    input  diff, x, y, obj_code,
    output cmd_done, busy, lcd_cs_n, lcd_wr_n, lcd_dc, lcd_data
  );
endinterface

// File: rtl/cell_drawer.sv
// cell_drawer: paints one 16x16 map cell on a parallel-bus LCD.
// A request latches the cell position and object code, then streams
// CASET / PASET / RAMWR commands followed by 256 RGB565 pixels.
// Each byte occupies two cycles: strobe low, then strobe high with the
// bus held so the panel latches on the rising edge of lcd_wr_n.
module cell_drawer (
  input  logic        clk,
  input  logic        rst,
  cell_drawer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_PIXELS,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [8:0] r_idx;
  logic [8:0] w_idx_nxt;
  logic       r_ph;
  logic       w_ph_nxt;
  logic       r_armed;
  logic       w_armed_nxt;
  logic       w_accept;
  logic [8:0] w_last;
  logic       w_in_byte;

  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [2:0] r_obj;

  logic [15:0] w_color;
  logic [7:0]  w_data;
  logic        w_dc;

  // FSM state, byte index, strobe phase and re-arm flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ph    <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ph    <= w_ph_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // Request capture; later input changes are ignored until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_obj <= '0;
    end else if (w_accept) begin
      r_x   <= bus.x;
      r_y   <= bus.y;
      r_obj <= bus.obj_code;
    end
  end

  // Next-state logic: acceptance, byte/phase stepping and state chaining
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ph_nxt    = r_ph;
    w_accept    = 1'b0;
    w_in_byte   = 1'b0;
    w_last      = '0;

    case (r_state)
      S_CASET, S_PASET: begin w_in_byte = 1'b1; w_last = 9'd4;   end
      S_RAMWR:          begin w_in_byte = 1'b1; w_last = 9'd0;   end
      S_PIXELS:         begin w_in_byte = 1'b1; w_last = 9'd511; end
      default:          ;
    endcase

    case (r_state)
      S_IDLE: begin
        if (bus.diff && r_armed) begin
          w_accept    = 1'b1;
          w_idx_nxt   = '0;
          w_ph_nxt    = 1'b0;
          // Rows beyond the map are accepted but skip straight to DONE
          w_state_nxt = (bus.y >= 4'd12) ? S_DONE : S_CASET;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        if (!r_ph) begin
          w_ph_nxt = 1'b1;
        end else begin
          w_ph_nxt = 1'b0;
          if (r_idx == w_last) begin
            w_idx_nxt = '0;
            case (r_state)
              S_CASET: w_state_nxt = S_PASET;
              S_PASET: w_state_nxt = S_RAMWR;
              S_RAMWR: w_state_nxt = S_PIXELS;
              default: w_state_nxt = S_DONE;
            endcase
          end else begin
            w_idx_nxt = r_idx + 9'd1;
          end
        end
      end
    endcase

    // A low diff re-arms; acceptance (diff high) consumes the arm
    if (!bus.diff)
      w_armed_nxt = 1'b1;
    else if (w_accept)
      w_armed_nxt = 1'b0;
    else
      w_armed_nxt = r_armed;
  end

  // Object code to RGB565 colour
  always_comb begin
    case (r_obj)
      3'd0:    w_color = 16'h0000;
      3'd1:    w_color = 16'h07E0;
      3'd2:    w_color = 16'h001F;
      3'd3:    w_color = 16'hF800;
      3'd4:    w_color = 16'hFFFF;
      default: w_color = 16'h8410;
    endcase
  end

  // Byte and D/C selection for the current state and byte index
  always_comb begin
    w_data = 8'h00;
    w_dc   = 1'b0;
    case (r_state)
      S_CASET: begin
        w_dc = (r_idx != 9'd0);
        case (r_idx[2:0])
          3'd0:    w_data = 8'h2A;
          3'd2:    w_data = {r_x, 4'h0};
          3'd4:    w_data = {r_x, 4'hF};
          default: w_data = 8'h00;
        endcase
      end
      S_PASET: begin
        w_dc = (r_idx != 9'd0);
        case (r_idx[2:0])
          3'd0:    w_data = 8'h2B;
          3'd2:    w_data = {r_y, 4'h0};
          3'd4:    w_data = {r_y, 4'hF};
          default: w_data = 8'h00;
        endcase
      end
      S_RAMWR: begin
        w_dc   = 1'b0;
        w_data = 8'h2C;
      end
      S_PIXELS: begin
        w_dc   = 1'b1;
        w_data = r_idx[0] ? w_color[7:0] : w_color[15:8];
      end
      default: ;
    endcase
  end

  assign bus.lcd_cs_n = ~w_in_byte;
  assign bus.lcd_wr_n = ~(w_in_byte & ~r_ph);
  assign bus.lcd_dc   = w_dc;
  assign bus.lcd_data = w_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.cmd_done = (r_state == S_DONE);

endmodule

// File: tb/tb_cell_drawer.sv
// Self-checking bench for cell_drawer: every cycle of each draw is compared
// against a byte list built from the cell/colour rules.
module tb_cell_drawer;

  logic clk;
  logic rst;

  cell_drawer_if bus_if ();

  cell_drawer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // {cs_n, wr_n, dc, data[7:0], busy, cmd_done}
  localparam logic [12:0] RESET_VEC = 13'h1800;

  logic [8:0] exp_b [0:522];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obj_color(input logic [2:0] o);
    case (o)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h07E0;
      3'd2:    return 16'h001F;
      3'd3:    return 16'hF800;
      3'd4:    return 16'hFFFF;
      default: return 16'h8410;
    endcase
  endfunction

  // Reference byte stream: {dc, data}
  task automatic build_model(input int cx, input int cy, input logic [2:0] o);
    logic [15:0] c;
    int lo_x, lo_y, hi_x, hi_y;
    c    = obj_color(o);
    lo_x = cx * 16;  hi_x = cx * 16 + 15;
    lo_y = cy * 16;  hi_y = cy * 16 + 15;
    exp_b[0]  = {1'b0, 8'h2A};
    exp_b[1]  = {1'b1, 8'h00};
    exp_b[2]  = {1'b1, 8'(lo_x)};
    exp_b[3]  = {1'b1, 8'h00};
    exp_b[4]  = {1'b1, 8'(hi_x)};
    exp_b[5]  = {1'b0, 8'h2B};
    exp_b[6]  = {1'b1, 8'h00};
    exp_b[7]  = {1'b1, 8'(lo_y)};
    exp_b[8]  = {1'b1, 8'h00};
    exp_b[9]  = {1'b1, 8'(hi_y)};
    exp_b[10] = {1'b0, 8'h2C};
    for (int p = 0; p < 256; p++) begin
      exp_b[11 + 2*p]     = {1'b1, c[15:8]};
      exp_b[11 + 2*p + 1] = {1'b1, c[7:0]};
    end
  endtask

  function automatic logic [12:0] sample();
    return {bus_if.lcd_cs_n, bus_if.lcd_wr_n, bus_if.lcd_dc, bus_if.lcd_data,
            bus_if.busy, bus_if.cmd_done};
  endfunction

  // Expected outputs in cycle n after acceptance (cycle 1 follows the accept edge)
  function automatic logic [12:0] expect_vec(input int n, input int total);
    int k;
    logic ph;
    if (n <= total) begin
      k  = (n - 1) / 2;
      ph = 1'((n - 1) % 2);
      return {1'b0, ph, exp_b[k], 1'b1, 1'b0};
    end else if (n == total + 1) begin
      return {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    end
    return RESET_VEC;
  endfunction

  // Issue one request at a negedge and check every following cycle.
  // abort_at > 0 raises rst in that cycle and leaves rst high on return.
  task automatic run_draw(input string tag, input logic [3:0] dx, input logic [3:0] dy,
                          input logic [2:0] dobj, input bit tog, input int abort_at);
    int total;
    int done_at;
    build_model(int'(dx), int'(dy), dobj);
    total   = (dy < 4'd12) ? 1046 : 0;
    done_at = 0;
    bus_if.diff     = 1'b1;
    bus_if.x        = dx;
    bus_if.y        = dy;
    bus_if.obj_code = dobj;
    @(posedge clk);
    for (int n = 1; n <= total + 6; n++) begin
      @(negedge clk);
      if (abort_at != 0 && n == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq({tag, "_async_reset"}, int'(sample()), int'(RESET_VEC));
        break;
      end
      check_eq(tag, int'(sample()), int'(expect_vec(n, total)));
      if (bus_if.cmd_done && done_at == 0) done_at = n;
      if (tog) begin
        bus_if.x        = 4'($urandom);
        bus_if.y        = 4'($urandom);
        bus_if.obj_code = 3'($urandom);
      end
    end
    if (abort_at == 0) check_eq({tag, "_done_cycle"}, done_at, total + 1);
    bus_if.diff = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int falls;
    int cs_low;
    logic prev_wr;

    rst             = 1'b1;
    bus_if.diff     = 1'b0;
    bus_if.x        = '0;
    bus_if.y        = '0;
    bus_if.obj_code = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_vals", int'(sample()), int'(RESET_VEC));
    rst = 1'b0;

    // Idle with diff low: no strobes, chip select never active
    falls   = 0;
    cs_low  = 0;
    prev_wr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev_wr && !bus_if.lcd_wr_n) falls++;
      if (!bus_if.lcd_cs_n) cs_low++;
      prev_wr = bus_if.lcd_wr_n;
    end
    check_eq("idle_wr_falls", falls, 0);
    check_eq("idle_cs_low", cs_low, 0);
    check_eq("idle_vals", int'(sample()), int'(RESET_VEC));

    run_draw("draw_4_4_head", 4'd4, 4'd4, 3'd2, 1'b0, 0);
    run_draw("draw_15_11_border", 4'd15, 4'd11, 3'd4, 1'b0, 0);
    run_draw("draw_y13", 4'd3, 4'd13, 3'd1, 1'b0, 0);

    // Abort at byte 200 phase 0, hold reset, then redraw
    run_draw("draw_abort", 4'd5, 4'd6, 3'd1, 1'b0, 401);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_hold", int'(sample()), int'(RESET_VEC));
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_release", int'(sample()), int'(RESET_VEC));
    run_draw("draw_after_abort", 4'd7, 4'd4, 3'd3, 1'b0, 0);

    run_draw("draw_toggle", 4'd9, 4'd2, 3'd5, 1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      run_draw("draw_rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               3'($urandom), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
